halloween_sequencer: RTL and testbench

Parametrised opcode sequencer for the Halloween decoration controller. It stores a program of NUM_SLOTS 4-bit effect opcodes loaded through a valid/ready handshake and steps through them with a programmable per-slot dwell time. Each active opcode drives a 16-bit one-hot effect bus plus a sticky colour register, with optional looping. It sits between the host/testbench stimulus and the decoration actuators (fog, lights, sound, movement).

---
 rtl/halloween_pkg.sv | 37 +++
 rtl/halloween_sequencer_hw_op_decode.sv | 22 ++
 rtl/halloween_sequencer.sv | 139 +++++++++++++
 tb/tb_halloween_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/halloween_pkg.sv
// rtl/halloween_pkg.sv - opcodes, sequencer states and colour codes for the Halloween sequencer
package halloween_pkg;

    localparam logic [3:0] OP_ON     = 4'b0000;
    localparam logic [3:0] OP_RESET  = 4'b0001;
    localparam logic [3:0] OP_NOOP   = 4'b0010;
    localparam logic [3:0] OP_FOG    = 4'b0011;
    localparam logic [3:0] OP_GREEN  = 4'b0100;
    localparam logic [3:0] OP_PURPLE = 4'b0101;
    localparam logic [3:0] OP_ORANGE = 4'b0110;
    localparam logic [3:0] OP_SCREAM = 4'b1000;
    localparam logic [3:0] OP_CACKLE = 4'b1001;
    localparam logic [3:0] OP_BOO    = 4'b1010;
    localparam logic [3:0] OP_WAVE   = 4'b1100;
    localparam logic [3:0] OP_JAW    = 4'b1101;

    localparam logic [1:0] COL_NONE   = 2'b00;
    localparam logic [1:0] COL_GREEN  = 2'b01;
    localparam logic [1:0] COL_PURPLE = 2'b10;
    localparam logic [1:0] COL_ORANGE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } seq_state_t;

    function automatic logic [1:0] color_of(input logic [3:0] op);
        case (op)
            OP_GREEN:  return COL_GREEN;
            OP_PURPLE: return COL_PURPLE;
            OP_ORANGE: return COL_ORANGE;
            default:   return COL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/halloween_sequencer_hw_op_decode.sv
// rtl/halloween_sequencer_hw_op_decode.sv - combinational opcode classifier and effect one-hot
module hw_op_decode
    import halloween_pkg::*;
(
    input  logic [3:0]  op,
    output logic [15:0] one_hot,
    output logic        is_terminator,
    output logic        is_reset,
    output logic        is_color,
    output logic        is_illegal
);

    always_comb begin
        is_terminator = (op == OP_ON);
        is_reset      = (op == OP_RESET);
        is_color      = (op == OP_GREEN) || (op == OP_PURPLE) || (op == OP_ORANGE);
        is_illegal    = (op == 4'b0111) || (op == 4'b1011) || (op == 4'b1110) || (op == 4'b1111);
        // Terminators never show on the bus; undefined opcodes dwell silently.
        one_hot       = (is_terminator || is_illegal) ? 16'h0000 : (16'h0001 << op);
    end

endmodule

// File: rtl/halloween_sequencer.sv
// rtl/halloween_sequencer.sv - programmable opcode sequencer driving effect bus and colour
module halloween_sequencer
    import halloween_pkg::*;
#(
    parameter  int NUM_SLOTS = 4,
    parameter  int HOLD_W    = 4,
    localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   prog_valid,
    output logic                   prog_ready,
    input  logic [4*NUM_SLOTS-1:0] prog_data,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   loop_en,
    input  logic [HOLD_W-1:0]      hold_cycles,
    output logic [15:0]            effect_oh,
    output logic [1:0]             color,
    output logic [SLOT_W-1:0]      cur_slot,
    output logic                   busy,
    output logic                   done,
    output logic                   illegal_op
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    seq_state_t             state;
    logic [4*NUM_SLOTS-1:0] prog_q;
    logic [HOLD_W-1:0]      cnt;

    logic [3:0]        cur_op, tgt_op, ent_op;
    logic [SLOT_W-1:0] tgt, ent;
    logic              want_raw, halt_raw, enter, to_halt;
    logic [15:0]       tgt_oh, ent_oh;
    logic              tgt_term, tgt_rst, tgt_col, tgt_ill;
    logic              ent_term, ent_rst, ent_col, ent_ill;

    assign cur_op = prog_q[4*cur_slot +: 4];
    assign tgt_op = prog_q[4*tgt +: 4];
    assign ent_op = prog_q[4*ent +: 4];

    // Where execution wants to go next, before resolving terminators.
    always_comb begin
        tgt      = '0;
        want_raw = 1'b0;
        halt_raw = 1'b0;
        if (state == S_RUN) begin
            if (cnt == '0) begin
                if (cur_op == OP_RESET) begin
                    want_raw = 1'b1;
                end else if (cur_slot == LAST_SLOT) begin
                    want_raw = loop_en;
                    halt_raw = !loop_en;
                end else begin
                    want_raw = 1'b1;
                    tgt      = cur_slot + 1'b1;
                end
            end
        end else if (start) begin
            want_raw = 1'b1;
        end
    end

    // A terminator takes no time: fold it into a wrap to slot 0 or a halt.
    always_comb begin
        ent     = tgt;
        enter   = want_raw;
        to_halt = halt_raw;
        if (want_raw && tgt_term) begin
            ent = '0;
            if (tgt == '0 || !loop_en || prog_q[3:0] == OP_ON) begin
                enter   = 1'b0;
                to_halt = 1'b1;
            end
        end
    end

    hw_op_decode u_dec_tgt (
        .op(tgt_op), .one_hot(tgt_oh), .is_terminator(tgt_term),
        .is_reset(tgt_rst), .is_color(tgt_col), .is_illegal(tgt_ill)
    );

    hw_op_decode u_dec_ent (
        .op(ent_op), .one_hot(ent_oh), .is_terminator(ent_term),
        .is_reset(ent_rst), .is_color(ent_col), .is_illegal(ent_ill)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            prog_q     <= '0;
            cnt        <= '0;
            prog_ready <= 1'b1;
            effect_oh  <= '0;
            color      <= COL_NONE;
            cur_slot   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state      <= S_IDLE;
                cnt        <= '0;
                prog_ready <= 1'b1;
                effect_oh  <= '0;
                color      <= COL_NONE;
                cur_slot   <= '0;
                busy       <= 1'b0;
            end else if (prog_valid && prog_ready) begin
                prog_q     <= prog_data;
                illegal_op <= 1'b0;
            end else if (enter) begin
                state      <= S_RUN;
                prog_ready <= 1'b0;
                busy       <= 1'b1;
                cur_slot   <= ent;
                effect_oh  <= ent_oh;
                cnt        <= ent_rst ? '0 : hold_cycles;
                if (ent_col)
                    color <= color_of(ent_op);
                else if (ent_rst)
                    color <= COL_NONE;
                if (ent_ill)
                    illegal_op <= 1'b1;
            end else if (to_halt) begin
                state      <= S_HALT;
                prog_ready <= 1'b1;
                busy       <= 1'b0;
                effect_oh  <= '0;
                done       <= 1'b1;
            end else if (state == S_RUN) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_halloween_sequencer.sv
// tb/tb_halloween_sequencer.sv - directed self-checking bench for halloween_sequencer
module tb_halloween_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog_valid;
    logic        prog_ready;
    logic [15:0] prog_data;
    logic        start;
    logic        abort;
    logic        loop_en;
    logic [3:0]  hold_cycles;
    logic [15:0] effect_oh;
    logic [1:0]  color;
    logic [1:0]  cur_slot;
    logic        busy;
    logic        done;
    logic        illegal_op;

    int n_cmp = 0;
    int n_err = 0;

    halloween_sequencer #(.NUM_SLOTS(4), .HOLD_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .prog_valid(prog_valid), .prog_ready(prog_ready),
        .prog_data(prog_data), .start(start), .abort(abort), .loop_en(loop_en),
        .hold_cycles(hold_cycles), .effect_oh(effect_oh), .color(color),
        .cur_slot(cur_slot), .busy(busy), .done(done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] d);
        prog_valid = 1'b1;
        prog_data  = d;
        tick();
        prog_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [15:0] exp_fx [4];

    initial begin
        rst_n = 1'b0; prog_valid = 1'b0; prog_data = '0; start = 1'b0;
        abort = 1'b0; loop_en = 1'b0; hold_cycles = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_ready",  prog_ready, 1);
        chk("rst_effect", effect_oh, 0);
        chk("rst_busy",   {color, cur_slot, busy, done, illegal_op}, 0);

        // slot0 SCREAM, slot1 FOG, slot2 GREEN, slot3 BOO
        load(16'hA438);
        go();
        chk("t1_c0_fx", effect_oh, 16'h0100);
        chk("t1_c0_busy", busy, 1);
        chk("t1_c0_ready", prog_ready, 0);
        tick();
        chk("t1_c1_fx", effect_oh, 16'h0008);
        chk("t1_c1_col", color, 0);
        tick();
        chk("t1_c2_fx", effect_oh, 16'h0010);
        chk("t1_c2_col", color, 1);
        tick();
        chk("t1_c3_fx", effect_oh, 16'h0400);
        chk("t1_c3_slot", cur_slot, 3);
        tick();
        chk("t1_halt_done", done, 1);
        chk("t1_halt_fx", effect_oh, 0);
        chk("t1_halt_state", {busy, prog_ready, color, cur_slot}, {1'b0, 1'b1, 2'b01, 2'b11});
        tick();
        chk("t1_done_pulse", done, 0);

        // Same program with hold=2: every effect held 3 cycles, 12 RUN cycles total.
        exp_fx[0] = 16'h0100; exp_fx[1] = 16'h0008; exp_fx[2] = 16'h0010; exp_fx[3] = 16'h0400;
        hold_cycles = 4'd2;
        go();
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t2_fx%0d", i), effect_oh, exp_fx[i/3]);
            chk($sformatf("t2_busy%0d", i), busy, 1);
            tick();
        end
        chk("t2_end_done", done, 1);
        chk("t2_end_busy", busy, 0);
        hold_cycles = 4'd0;

        // Load and start in the same cycle: start ignored.
        prog_valid = 1'b1; start = 1'b1; prog_data = 16'hAA04;
        tick();
        prog_valid = 1'b0; start = 1'b0;
        chk("ld_start_busy", busy, 0);

        // slot0 GREEN, slot1 ON, loop: GREEN forever on slot 0.
        loop_en = 1'b1;
        go();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_fx%0d", i), effect_oh, 16'h0010);
            chk($sformatf("t3_slot%0d", i), cur_slot, 0);
            tick();
        end
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t3_abort", {busy, effect_oh, color}, {1'b0, 16'h0, 2'b00});
        loop_en = 1'b0;

        // slot0 ORANGE, slot1 RESET, slots2/3 NOOP
        load(16'h2216);
        go();
        chk("t4_c0", {effect_oh, color, cur_slot}, {16'h0040, 2'b11, 2'd0});
        tick();
        chk("t4_c1", {effect_oh, color, cur_slot}, {16'h0002, 2'b00, 2'd1});
        tick();
        chk("t4_c2", {effect_oh, color, cur_slot}, {16'h0040, 2'b11, 2'd0});
        abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
        chk("t4_abort", {busy, effect_oh, color, cur_slot, prog_ready}, {1'b0, 16'h0, 2'b00, 2'd0, 1'b1});

        // slot0 NOOP, slot1 FOG, slot2 1111, slot3 FOG
        load(16'h3F32);
        chk("t5_ill_clear", illegal_op, 0);
        go();
        chk("t5_c0", effect_oh, 16'h0004);
        prog_valid = 1'b1; prog_data = 16'h9999;
        tick();
        chk("t5_c1", effect_oh, 16'h0008);
        chk("t5_ready_run", prog_ready, 0);
        tick();
        chk("t5_c2_fx", effect_oh, 16'h0000);
        chk("t5_c2_ill", {illegal_op, busy, cur_slot}, {1'b1, 1'b1, 2'd2});
        prog_valid = 1'b0;
        tick();
        chk("t5_c3", effect_oh, 16'h0008);
        tick();
        chk("t5_halt", {done, illegal_op}, 2'b11);
        go();
        chk("t5_rerun_c0", effect_oh, 16'h0004);
        tick();
        chk("t5_rerun_c1", effect_oh, 16'h0008);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t5_ill_sticky", illegal_op, 1);
        load(16'hA438);
        chk("t5_ill_reload", illegal_op, 0);

        // Asynchronous reset mid-dwell on the GREEN slot.
        hold_cycles = 4'd3;
        go();
        for (int i = 0; i < 9; i++) tick();
        chk("t6_pre", {effect_oh, color, cur_slot}, {16'h0010, 2'b01, 2'd2});
        rst_n = 1'b0;
        #1;
        chk("t6_async", {effect_oh, color, cur_slot, busy, done, illegal_op}, 0);
        chk("t6_ready", prog_ready, 1);
        #2;
        rst_n = 1'b1;
        tick();
        go();
        chk("t6_empty_start", {done, busy, effect_oh}, {1'b1, 1'b0, 16'h0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
